bram_port_arbiter: RTL

//  Shares one bram_unaligned (2 KB, 1-cycle read latency, 32-bit unaligned write)

---
 rtl/bram_port_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one unaligned 32-bit RAM between a fetch read port (A)
// and a load/store port (B); sub-word stores become a read-modify-write pair.
module bram_port_arbiter #(
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  a_req,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   output logic                  a_ready,
   output logic                  a_rvalid,
   output logic [31:0]           a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [1:0]            b_size,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [31:0]           b_wdata,
   output logic                  b_ready,
   output logic                  b_rvalid,
   output logic [31:0]           b_rdata,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [31:0]           ram_wdata,
   output logic                  ram_wren,
   input  logic [31:0]           ram_rdata
);

   localparam logic [0:0] RUN = 1'b0;
   localparam logic [0:0] RMW = 1'b1;

   logic [0:0]            state_reg;
   logic                  a_prio_reg;
   logic [ADDR_WIDTH-1:0] raddr_reg;
   logic [ADDR_WIDTH-1:0] cap_addr_reg;
   logic                  cap_half_reg;
   logic [15:0]           cap_wdata_reg;
   logic [1:0]            load_size_reg;
   logic                  a_rvalid_reg;
   logic                  b_rvalid_reg;

   logic        in_rmw;
   logic        grant_a;
   logic        grant_b;
   logic        b_word;
   logic [31:0] merged;
   logic [31:0] load_data;

   assign in_rmw  = (state_reg == RMW);
   assign b_word  = b_size[1];
   // a_prio_reg set means A wins a tie; it flips toward the port not just served
   assign grant_a = !reset && !in_rmw && a_req && (!b_req || a_prio_reg);
   assign grant_b = !reset && !in_rmw && b_req && (!a_req || !a_prio_reg);

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   assign ram_raddr = grant_a ? a_addr :
                      (grant_b && !(b_we && b_word)) ? b_addr : raddr_reg;
   assign ram_waddr = in_rmw ? cap_addr_reg : b_addr;
   assign ram_wdata = in_rmw ? merged : b_wdata;
   assign ram_wren  = !reset && (in_rmw || (grant_b && b_we && b_word));

   assign merged = cap_half_reg ? {ram_rdata[31:16], cap_wdata_reg}
                                : {ram_rdata[31:8], cap_wdata_reg[7:0]};

   // Zero-extend loads: byte 0 always kept, byte 1 for half/word, upper bytes for word
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_load_mask
         assign load_data[8*gi +: 8] =
            ((gi == 0) || ((gi == 1) && (load_size_reg != 2'd0)) || load_size_reg[1])
            ? ram_rdata[8*gi +: 8] : 8'h00;
      end
   endgenerate

   assign a_rvalid = a_rvalid_reg;
   assign b_rvalid = b_rvalid_reg;
   assign a_rdata  = a_rvalid_reg ? ram_rdata : 32'h0;
   assign b_rdata  = b_rvalid_reg ? load_data : 32'h0;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= RUN;
         a_prio_reg    <= 1'b1;
         raddr_reg     <= '0;
         cap_addr_reg  <= '0;
         cap_half_reg  <= 1'b0;
         cap_wdata_reg <= 16'h0;
         load_size_reg <= 2'd0;
         a_rvalid_reg  <= 1'b0;
         b_rvalid_reg  <= 1'b0;
      end else begin
         a_rvalid_reg <= grant_a;
         b_rvalid_reg <= grant_b && !b_we;
         raddr_reg    <= ram_raddr;
         if (grant_a) begin
            a_prio_reg <= 1'b0;
         end else if (grant_b) begin
            a_prio_reg <= 1'b1;
         end
         if (grant_b) begin
            load_size_reg <= b_size;
         end
         if (grant_b && b_we && !b_word) begin
            state_reg     <= RMW;
            cap_addr_reg  <= b_addr;
            cap_half_reg  <= b_size[0];
            cap_wdata_reg <= b_wdata[15:0];
         end else begin
            state_reg <= RUN;
         end
      end
   end

endmodule
